pc_seq_unit: RTL and testbench
==============================

# pc_seq_unit

Parametrised program-counter sequencer for the MIPS32 fetch stage; successor to the single-register PC latch. Holds the fetch PC and increments it under a valid/ready handshake with instruction memory. Accepts stall, halt and branch/jump redirects, and inserts a one-cycle bubble after every redirect. Optionally captures an exception PC (EPC) and supports return-from-exception.

## Interface
- ADDR_W, 32, PC width in bits (≥8)
- RESET_VEC, 32'h0040_0000, PC value loaded by reset (truncated to ADDR_W)
- EXC_VEC, 32'h8000_0180, exception handler entry (used only with PC_EPC_EN)
- INC, 4, byte increment per accepted fetch

Ports:
- clk  in  1  rising-edge clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  freeze PC and state; pc_valid keeps its current value
- halt  in  1  enter HALTED; leave only via redirect, exception or reset
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_pc  in  ADDR_W  redirect target
- fetch_ready  in  1  instruction memory accepts pc this cycle
- pc  out  ADDR_W  current fetch address
- pc_valid  out  1  pc is a real fetch request
- pc_next_seq  out  ADDR_W  pc + INC, combinational, modulo 2^ADDR_W
- misalign  out  1  one-cycle pulse: last accepted redirect target had pc[1:0]≠0
- exc_req  in  1  (PC_EPC_EN) take exception
- eret  in  1  (PC_EPC_EN) return to epc
- epc  out  ADDR_W  (PC_EPC_EN) captured exception PC

## Operation
- FSM states: BOOT, RUN, BUBBLE, HALTED.
- Reset (asynchronous): pc=RESET_VEC, state=BOOT, pc_valid=0, misalign=0, epc=0.
- BOOT → RUN after one clk with rst low; pc is unchanged.
- RUN: pc_valid=1. On fire = pc_valid & fetch_ready & ~stall: pc ← pc+INC.
- Per-cycle event priority: exc_req > redirect_valid > eret > halt > stall > fire > hold.
- redirect: pc ← {redirect_pc[ADDR_W-1:2],2'b00}, state ← BUBBLE, misalign ← |redirect_pc[1:0]. Accepted in any state except BOOT, and accepted even during stall.
- BUBBLE: pc_valid=0, pc held; → RUN next cycle unless a higher-priority event occurs.
- halt (RUN or BUBBLE): state ← HALTED, pc held, pc_valid=0.
- exc_req: epc ← pc, pc ← EXC_VEC, state ← BUBBLE.
- eret: pc ← epc, state ← BUBBLE.
- Increment wraps: pc of all-ones−INC+1 wraps to low addresses; no flag is raised.

## Timing
- The redirect asserted in cycle N is visible at pc in N+1 with pc_valid=0. pc_valid=1 in N+2.
- Fire-to-new-pc latency is one clock. Back-to-back fires give one address per cycle.
- stall without a redirect freezes pc, state and pc_valid exactly.
- fetch_ready low holds pc; pc_valid stays 1.
- misalign is high exactly one cycle, the cycle after the redirect.
- Reset asserted mid-operation forces reset values immediately and asynchronously. Release follows BOOT timing.

## Configuration
- PC_EPC_EN defined: exc_req, eret and epc ports exist; the EPC register and the exception/eret paths are present.
- PC_EPC_EN undefined: those ports and that logic are absent. Priority becomes redirect > halt > stall > fire > hold.

## Structure
- Shared package mips_pkg holds:
  - the state enum (BOOT, RUN, BUBBLE, HALTED);
  - default RESET_VEC, EXC_VEC and INC constants.
- One natural sub-module, pc_next_sel: combinational priority mux producing next pc, next state and misalign.

## Test plan
- Reset, then fetch_ready=1 for 4 cycles → pc_valid 0 in BOOT, then pc 0x00400000, 0x00400004, 0x00400008, 0x0040000C.
- Redirect to 0x00401002 while streaming → next cycle pc=0x00401000, pc_valid=0, misalign=1. Following cycle pc_valid=1, misalign=0.
- stall=1 with fetch_ready=1 for 3 cycles → pc held. Redirect during stall → still taken.
- halt from RUN → pc_valid=0 indefinitely. redirect to 0x00400100 → BUBBLE, then RUN at 0x00400100.
- ADDR_W=8, RESET_VEC=8'hF8: fire 3 times → pc F8, FC, 00, 04.
- PC_EPC_EN defined, at pc=0x00400010 with exc_req and redirect_valid in the same cycle:
  - → epc=0x00400010 and pc=0x80000180; the redirect is ignored.
  - Later eret → pc=0x00400010 after a one-cycle bubble.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS32 fetch-stage types and default constants used by the PC sequencer.
package mips_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        BUBBLE = 2'd2,
        HALTED = 2'd3
    } pc_state_t;

    localparam logic [31:0] PC_RESET_VEC = 32'h0040_0000;
    localparam logic [31:0] PC_EXC_VEC   = 32'h8000_0180;
    localparam int          PC_INC       = 4;

endpackage

// File: rtl/pc_seq_unit_next_sel.sv
// pc_next_sel: combinational priority mux choosing next PC, next state and misalign.
// Exception/eret paths are present only when PC_EPC_EN is defined.
module pc_next_sel
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32
`ifdef PC_EPC_EN
    , parameter logic [ADDR_W-1:0] EXC_PC = '0
`endif
) (
    input  pc_state_t         state,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] pc_seq,
    input  logic              stall,
    input  logic              halt,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              fetch_ready,
`ifdef PC_EPC_EN
    input  logic              exc_req,
    input  logic              eret,
    input  logic [ADDR_W-1:0] epc,
    output logic              epc_load,
`endif
    output logic [ADDR_W-1:0] pc_nxt,
    output pc_state_t         state_nxt,
    output logic              misalign_nxt
);

    always_comb begin
        pc_nxt       = pc;
        state_nxt    = state;
        misalign_nxt = 1'b0;
`ifdef PC_EPC_EN
        epc_load     = 1'b0;
`endif
        // BOOT ignores every event and always spends exactly one cycle
        if (state == BOOT) begin
            state_nxt = RUN;
        end
`ifdef PC_EPC_EN
        else if (exc_req) begin
            pc_nxt    = EXC_PC;
            state_nxt = BUBBLE;
            epc_load  = 1'b1;
        end
`endif
        else if (redirect_valid) begin
            pc_nxt       = {redirect_pc[ADDR_W-1:2], 2'b00};
            state_nxt    = BUBBLE;
            misalign_nxt = |redirect_pc[1:0];
        end
`ifdef PC_EPC_EN
        else if (eret && (state != HALTED)) begin
            pc_nxt    = epc;
            state_nxt = BUBBLE;
        end
`endif
        else if (halt) begin
            state_nxt = HALTED;
        end
        else if (!stall) begin
            if (state == BUBBLE) begin
                state_nxt = RUN;
            end else if ((state == RUN) && fetch_ready) begin
                pc_nxt = pc_seq;
            end
        end
    end

endmodule

// File: rtl/pc_seq_unit.sv
// pc_seq_unit: MIPS32 fetch PC sequencer with handshake, stall, halt and redirect bubble.
// Define PC_EPC_EN to add the exception PC register with exc_req/eret/epc ports.
module pc_seq_unit
    import mips_pkg::*;
#(
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] RESET_VEC = PC_RESET_VEC,
`ifdef PC_EPC_EN
    parameter logic [31:0] EXC_VEC   = PC_EXC_VEC,
`endif
    parameter int          INC       = PC_INC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              halt,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              fetch_ready,
`ifdef PC_EPC_EN
    input  logic              exc_req,
    input  logic              eret,
    output logic [ADDR_W-1:0] epc,
`endif
    output logic [ADDR_W-1:0] pc,
    output logic              pc_valid,
    output logic [ADDR_W-1:0] pc_next_seq,
    output logic              misalign
);

    localparam logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_VEC);
    localparam logic [ADDR_W-1:0] INC_W    = ADDR_W'(INC);

    pc_state_t         state_q;
    pc_state_t         state_nxt;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_nxt;
    logic              misalign_q;
    logic              misalign_nxt;
`ifdef PC_EPC_EN
    logic [ADDR_W-1:0] epc_q;
    logic              epc_load;
`endif

    // Sequential increment wraps naturally modulo 2^ADDR_W
    assign pc_next_seq = pc_q + INC_W;
    assign pc_valid    = (state_q == RUN);
    assign pc          = pc_q;
    assign misalign    = misalign_q;

    pc_next_sel #(
        .ADDR_W (ADDR_W)
`ifdef PC_EPC_EN
        , .EXC_PC (ADDR_W'(EXC_VEC))
`endif
    ) u_next_sel (
        .state          (state_q),
        .pc             (pc_q),
        .pc_seq         (pc_next_seq),
        .stall          (stall),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_ready    (fetch_ready),
`ifdef PC_EPC_EN
        .exc_req        (exc_req),
        .eret           (eret),
        .epc            (epc_q),
        .epc_load       (epc_load),
`endif
        .pc_nxt         (pc_nxt),
        .state_nxt      (state_nxt),
        .misalign_nxt   (misalign_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            state_q    <= BOOT;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_nxt;
            state_q    <= state_nxt;
            misalign_q <= misalign_nxt;
        end
    end

`ifdef PC_EPC_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            epc_q <= '0;
        end else if (epc_load) begin
            epc_q <= pc_q;
        end
    end

    assign epc = epc_q;
`endif

endmodule

// File: tb/tb_pc_seq_unit.sv
// Directed testbench for pc_seq_unit: 32-bit default instance plus an 8-bit wrap instance.
// EPC checks run only when PC_EPC_EN is defined.
module tb_pc_seq_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, halt, redirect_valid, fetch_ready;
    logic [31:0] redirect_pc;
    logic [31:0] pc, pc_next_seq;
    logic        pc_valid, misalign;
`ifdef PC_EPC_EN
    logic        exc_req, eret;
    logic [31:0] epc;
    logic        exc_req8, eret8;
    logic [7:0]  epc8;
`endif

    logic        fetch_ready8;
    logic [7:0]  pc8, pc_next_seq8;
    logic        pc_valid8, misalign8;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pc_seq_unit dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_ready    (fetch_ready),
`ifdef PC_EPC_EN
        .exc_req        (exc_req),
        .eret           (eret),
        .epc            (epc),
`endif
        .pc             (pc),
        .pc_valid       (pc_valid),
        .pc_next_seq    (pc_next_seq),
        .misalign       (misalign)
    );

    pc_seq_unit #(.ADDR_W(8), .RESET_VEC(32'h0000_00F8)) dut8 (
        .clk            (clk),
        .rst            (rst),
        .stall          (1'b0),
        .halt           (1'b0),
        .redirect_valid (1'b0),
        .redirect_pc    (8'h00),
        .fetch_ready    (fetch_ready8),
`ifdef PC_EPC_EN
        .exc_req        (exc_req8),
        .eret           (eret8),
        .epc            (epc8),
`endif
        .pc             (pc8),
        .pc_valid       (pc_valid8),
        .pc_next_seq    (pc_next_seq8),
        .misalign       (misalign8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_pc(input string tag, input logic [31:0] exp_pc, input logic exp_vld, input logic exp_mis);
        check({tag, ".pc"}, pc, exp_pc);
        check({tag, ".vld"}, {31'd0, pc_valid}, {31'd0, exp_vld});
        check({tag, ".mis"}, {31'd0, misalign}, {31'd0, exp_mis});
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        fetch_ready = 1'b0; fetch_ready8 = 1'b0;
`ifdef PC_EPC_EN
        exc_req = 1'b0; eret = 1'b0; exc_req8 = 1'b0; eret8 = 1'b0;
`endif
        step(); step();
        check_pc("reset", 32'h0040_0000, 1'b0, 1'b0);
        check("reset.pc8", {24'd0, pc8}, 32'h0000_00F8);

        // Release: one BOOT cycle, then stream
        rst = 1'b0; fetch_ready = 1'b1;
        check_pc("boot", 32'h0040_0000, 1'b0, 1'b0);
        step(); check_pc("run0", 32'h0040_0000, 1'b1, 1'b0);
        step(); check_pc("run1", 32'h0040_0004, 1'b1, 1'b0);
        step(); check_pc("run2", 32'h0040_0008, 1'b1, 1'b0);
        step(); check_pc("run3", 32'h0040_000C, 1'b1, 1'b0);
        check("nextseq", pc_next_seq, 32'h0040_0010);

        // Misaligned redirect while streaming
        redirect_valid = 1'b1; redirect_pc = 32'h0040_1002;
        step(); check_pc("redir", 32'h0040_1000, 1'b0, 1'b1);
        redirect_valid = 1'b0;
        step(); check_pc("redir+1", 32'h0040_1000, 1'b1, 1'b0);
        step(); check_pc("redir+2", 32'h0040_1004, 1'b1, 1'b0);

        // Stall holds pc and pc_valid
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); check_pc("stall", 32'h0040_1004, 1'b1, 1'b0);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h0040_2000;
        step(); check_pc("stall.redir", 32'h0040_2000, 1'b0, 1'b0);
        redirect_valid = 1'b0;
        step(); check_pc("stall.bubble", 32'h0040_2000, 1'b0, 1'b0);
        stall = 1'b0;
        step(); check_pc("unstall", 32'h0040_2000, 1'b1, 1'b0);
        step(); check_pc("unstall.fire", 32'h0040_2004, 1'b1, 1'b0);

        // fetch_ready low holds pc with pc_valid still high
        fetch_ready = 1'b0;
        step(); check_pc("notready", 32'h0040_2004, 1'b1, 1'b0);
        fetch_ready = 1'b1;

        // Halt, then leave via redirect
        halt = 1'b1;
        step(); check_pc("halt", 32'h0040_2004, 1'b0, 1'b0);
        halt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); check_pc("halted", 32'h0040_2004, 1'b0, 1'b0);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h0040_0100;
        step(); check_pc("halt.redir", 32'h0040_0100, 1'b0, 1'b0);
        redirect_valid = 1'b0;
        step(); check_pc("halt.run", 32'h0040_0100, 1'b1, 1'b0);
        step(); check_pc("halt.fire", 32'h0040_0104, 1'b1, 1'b0);

        // Asynchronous reset mid-operation, no clock edge in between
        rst = 1'b1;
        #2;
        check_pc("async_rst", 32'h0040_0000, 1'b0, 1'b0);
        step();
        rst = 1'b0; fetch_ready8 = 1'b1;
        check_pc("boot2", 32'h0040_0000, 1'b0, 1'b0);
        check("boot2.vld8", {31'd0, pc_valid8}, 32'd0);

        // 8-bit instance wraps F8, FC, 00, 04
        step(); check("w8.0", {24'd0, pc8}, 32'h0000_00F8);
        check("w8.vld", {31'd0, pc_valid8}, 32'd1);
        check_pc("run2.0", 32'h0040_0000, 1'b1, 1'b0);
        step(); check("w8.1", {24'd0, pc8}, 32'h0000_00FC);
        check("w8.nextseq", {24'd0, pc_next_seq8}, 32'h0000_0000);
        step(); check("w8.2", {24'd0, pc8}, 32'h0000_0000);
        step(); check("w8.3", {24'd0, pc8}, 32'h0000_0004);
        check_pc("run2.3", 32'h0040_000C, 1'b1, 1'b0);
        step(); check_pc("run2.4", 32'h0040_0010, 1'b1, 1'b0);

`ifdef PC_EPC_EN
        // Exception wins over a simultaneous redirect
        exc_req = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0040_3000;
        step(); check_pc("exc", 32'h8000_0180, 1'b0, 1'b0);
        check("exc.epc", epc, 32'h0040_0010);
        exc_req = 1'b0; redirect_valid = 1'b0;
        step(); check_pc("exc.run", 32'h8000_0180, 1'b1, 1'b0);
        step(); check_pc("exc.fire", 32'h8000_0184, 1'b1, 1'b0);
        eret = 1'b1;
        step(); check_pc("eret", 32'h0040_0010, 1'b0, 1'b0);
        eret = 1'b0;
        step(); check_pc("eret.run", 32'h0040_0010, 1'b1, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
